apb_uart_fifo_ctrl: RTL and testbench

Second-generation APB register front-end for the UART TX/RX engines. It adds parametrised TX and RX FIFOs, a programmable baud divisor output, sticky error flags with write-1-to-clear, FIFO flush and a maskable interrupt. It sits between the APB bus and the existing UART_TX/UART_RX engines, which are instantiated beside it.

---
 rtl/uart_apb_pkg.sv | 38 +++
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/apb_uart_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_apb_uart_fifo_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared register map, bit positions and TX launch FSM states for the APB UART front-end.
package uart_apb_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_TXDATA   = 3'd2;
    localparam logic [2:0] REG_RXDATA   = 3'd3;
    localparam logic [2:0] REG_IRQ_EN   = 3'd4;
    localparam logic [2:0] REG_BAUD_DIV = 3'd5;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_TX_FLUSH = 2;
    localparam int CTRL_RX_FLUSH = 3;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_TX_ACTIVE  = 4;
    localparam int ST_RX_BUSY    = 5;
    localparam int ST_RX_OVR     = 6;
    localparam int ST_FRAME_ERR  = 7;
    localparam int ST_TX_OVF     = 8;
    localparam int ST_RX_LVL_LSB = 16;
    localparam int ST_TX_LVL_LSB = 24;

    localparam int IRQ_RX_NE    = 0;
    localparam int IRQ_TX_EMPTY = 1;
    localparam int IRQ_ERR      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; a separate count register tells full from empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign level = count_q;

endmodule

// File: rtl/apb_uart_fifo_ctrl.sv
// APB register front-end for the UART engines: TX/RX FIFOs, baud divisor,
// sticky W1C error flags, flush controls and a maskable registered interrupt.
module apb_uart_fifo_ctrl
    import uart_apb_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 10417
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              rx_en,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rx_error,
    input  logic              rx_busy,
    output logic [DIV_W-1:0]  baud_div,
    output logic              irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [DIV_W-1:0] DIV_RST = DEFAULT_DIV[DIV_W-1:0];

    logic              access, addr_ok, wr, rd;
    logic [2:0]        idx;
    logic              wr_ctrl, wr_status, wr_txdata, wr_irq_en, wr_baud, rd_rxdata;
    logic [DIV_W-1:0]  baud_wr_val;
    logic              unused_pwdata;

    logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic [TX_AW:0]    tx_level;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [RX_AW:0]    rx_level;
    logic [DATA_W-1:0] rx_head;

    logic              rx_ovr_set, frame_set, tx_ovf_set, tx_active;
    logic [31:0]       status_word;

    logic              ctrl_tx_en_q, ctrl_tx_en_d;
    logic              ctrl_rx_en_q, ctrl_rx_en_d;
    logic [2:0]        irq_en_q, irq_en_d;
    logic [DIV_W-1:0]  baud_div_q, baud_div_d;
    logic              rx_ovr_q, rx_ovr_d;
    logic              frame_err_q, frame_err_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              irq_q, irq_d;
    tx_state_e         tx_state_q;
    logic              tx_en_q;
    logic [DATA_W-1:0] tx_data_q;

    assign access      = PSEL & PENABLE;
    assign addr_ok     = (PADDR[31:3] == '0);
    assign idx         = PADDR[2:0];
    assign wr          = access & PWRITE & addr_ok;
    assign rd          = access & ~PWRITE & addr_ok;
    assign wr_ctrl     = wr & (idx == REG_CTRL);
    assign wr_status   = wr & (idx == REG_STATUS);
    assign wr_txdata   = wr & (idx == REG_TXDATA);
    assign wr_irq_en   = wr & (idx == REG_IRQ_EN);
    assign wr_baud     = wr & (idx == REG_BAUD_DIV);
    assign rd_rxdata   = rd & (idx == REG_RXDATA);
    assign baud_wr_val = PWDATA[DIV_W-1:0];
    assign unused_pwdata = ^PWDATA;

    // TX full is sampled before the launch pop, so a push on a full FIFO is always refused.
    assign tx_flush   = wr_ctrl & PWDATA[CTRL_TX_FLUSH];
    assign tx_push    = wr_txdata & ~tx_full;
    assign tx_pop     = (tx_state_q == LAUNCH);
    assign tx_ovf_set = wr_txdata & tx_full;

    assign rx_flush   = wr_ctrl & PWDATA[CTRL_RX_FLUSH];
    assign rx_pop     = rd_rxdata & ~rx_empty;
    assign rx_push    = rx_done & ctrl_rx_en_q & ~rx_error;
    assign rx_ovr_set = rx_push & rx_full & ~rx_pop & ~rx_flush;
    assign frame_set  = rx_done & ctrl_rx_en_q & rx_error;

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (PWDATA[DATA_W-1:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    assign tx_active = (tx_state_q != IDLE) | tx_busy;

    always_comb begin
        status_word                          = '0;
        status_word[ST_TX_EMPTY]             = tx_empty;
        status_word[ST_TX_FULL]              = tx_full;
        status_word[ST_RX_EMPTY]             = rx_empty;
        status_word[ST_RX_FULL]              = rx_full;
        status_word[ST_TX_ACTIVE]            = tx_active;
        status_word[ST_RX_BUSY]              = rx_busy;
        status_word[ST_RX_OVR]               = rx_ovr_q;
        status_word[ST_FRAME_ERR]            = frame_err_q;
        status_word[ST_TX_OVF]               = tx_ovf_q;
        status_word[ST_RX_LVL_LSB +: 8]      = 8'(rx_level);
        status_word[ST_TX_LVL_LSB +: 8]      = 8'(tx_level);
    end

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (idx)
                REG_CTRL:     PRDATA = {30'd0, ctrl_rx_en_q, ctrl_tx_en_q};
                REG_STATUS:   PRDATA = status_word;
                REG_RXDATA:   PRDATA = rx_empty ? 32'd0 : 32'(rx_head);
                REG_IRQ_EN:   PRDATA = {29'd0, irq_en_q};
                REG_BAUD_DIV: PRDATA = 32'(baud_div_q);
                default:      PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        PSLVERR = 1'b0;
        if (access) begin
            if (!addr_ok) begin
                PSLVERR = 1'b1;
            end else begin
                case (idx)
                    REG_TXDATA:   PSLVERR = PWRITE & tx_full;
                    REG_RXDATA:   PSLVERR = ~PWRITE & rx_empty;
                    REG_BAUD_DIV: PSLVERR = PWRITE & (baud_wr_val == '0);
                    3'd6, 3'd7:   PSLVERR = 1'b1;
                    default:      PSLVERR = 1'b0;
                endcase
            end
        end
    end

    // Sticky flags: a new error event overrides a simultaneous write-1-to-clear.
    always_comb begin
        ctrl_tx_en_d = ctrl_tx_en_q;
        ctrl_rx_en_d = ctrl_rx_en_q;
        irq_en_d     = irq_en_q;
        baud_div_d   = baud_div_q;
        if (wr_ctrl) begin
            ctrl_tx_en_d = PWDATA[CTRL_TX_EN];
            ctrl_rx_en_d = PWDATA[CTRL_RX_EN];
        end
        if (wr_irq_en) irq_en_d = PWDATA[2:0];
        if (wr_baud && (baud_wr_val != '0)) baud_div_d = baud_wr_val;
        rx_ovr_d    = (rx_ovr_q    & ~(wr_status & PWDATA[ST_RX_OVR]))    | rx_ovr_set;
        frame_err_d = (frame_err_q & ~(wr_status & PWDATA[ST_FRAME_ERR])) | frame_set;
        tx_ovf_d    = (tx_ovf_q    & ~(wr_status & PWDATA[ST_TX_OVF]))    | tx_ovf_set;
        irq_d = (irq_en_q[IRQ_RX_NE]    & ~rx_empty)
              | (irq_en_q[IRQ_TX_EMPTY] & tx_empty)
              | (irq_en_q[IRQ_ERR]      & (rx_ovr_q | frame_err_q | tx_ovf_q));
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_tx_en_q <= 1'b0;
            ctrl_rx_en_q <= 1'b0;
            irq_en_q     <= '0;
            baud_div_q   <= DIV_RST;
            rx_ovr_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_ovf_q     <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_tx_en_q <= ctrl_tx_en_d;
            ctrl_rx_en_q <= ctrl_rx_en_d;
            irq_en_q     <= irq_en_d;
            baud_div_q   <= baud_div_d;
            rx_ovr_q     <= rx_ovr_d;
            frame_err_q  <= frame_err_d;
            tx_ovf_q     <= tx_ovf_d;
            irq_q        <= irq_d;
        end
    end

    // A flush in the same cycle suppresses the launch so no discarded byte escapes.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_state_q <= IDLE;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_en_q <= 1'b0;
            case (tx_state_q)
                IDLE: begin
                    if (ctrl_tx_en_q && !tx_empty && !tx_busy && !tx_flush) begin
                        tx_state_q <= LAUNCH;
                        tx_en_q    <= 1'b1;
                        tx_data_q  <= tx_head;
                    end
                end
                LAUNCH:  tx_state_q <= WAIT;
                WAIT:    if (tx_done) tx_state_q <= IDLE;
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    assign PREADY   = access;
    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign rx_en    = ctrl_rx_en_q;
    assign baud_div = baud_div_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_apb_uart_fifo_ctrl.sv
// Directed plus randomized checks of the APB UART front-end against a queue-based model.
module tb_apb_uart_fifo_ctrl;
    localparam int DATA_W      = 8;
    localparam int TX_DEPTH    = 16;
    localparam int RX_DEPTH    = 16;
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 10417;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              PSEL, PENABLE, PWRITE;
    logic [31:0]       PADDR, PWDATA, PRDATA;
    logic              PREADY, PSLVERR;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy, tx_done;
    logic              rx_en;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done, rx_error, rx_busy;
    logic [DIV_W-1:0]  baud_div;
    logic              irq;

    always #5 PCLK = ~PCLK;

    apb_uart_fifo_ctrl #(
        .DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
        .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .rx_en(rx_en), .rx_data(rx_data),
        .rx_done(rx_done), .rx_error(rx_error), .rx_busy(rx_busy),
        .baud_div(baud_div), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] launched[$];
    logic [7:0] sent_exp[$];
    bit m_ovr, m_frame, m_txovf, m_rx_en;
    bit engine_hold = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit tx_act);
        logic [31:0] s;
        s        = '0;
        s[0]     = (txq.size() == 0);
        s[1]     = (txq.size() == TX_DEPTH);
        s[2]     = (rxq.size() == 0);
        s[3]     = (rxq.size() == RX_DEPTH);
        s[4]     = tx_act;
        s[6]     = m_ovr;
        s[7]     = m_frame;
        s[8]     = m_txovf;
        s[23:16] = 8'(rxq.size());
        s[31:24] = 8'(txq.size());
        return s;
    endfunction

    task automatic apb_write(input logic [2:0] idx, input logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {29'd0, idx}; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("APB WR idx=%0d data=0x%08h slverr=%b", idx, data, err);
    endtask

    task automatic apb_read(input logic [2:0] idx, output logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {29'd0, idx};
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 begin data = PRDATA; err = PSLVERR; end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("APB RD idx=%0d data=0x%08h slverr=%b", idx, data, err);
    endtask

    // Model update for one UART_RX completion.
    task automatic rx_char(input logic [7:0] d, input logic err);
        @(posedge PCLK); #1;
        rx_data = d; rx_done = 1'b1; rx_error = err;
        @(posedge PCLK); #1;
        rx_done = 1'b0; rx_error = 1'b0;
        if (m_rx_en) begin
            if (err) m_frame = 1'b1;
            else if (rxq.size() == RX_DEPTH) m_ovr = 1'b1;
            else rxq.push_back(d);
        end
        $display("RX char=0x%02h err=%b", d, err);
    endtask

    // UART_TX stand-in: records each launch and answers tx_done about 20 cycles later.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge PCLK); #1;
            if (tx_en === 1'b1) begin
                int wait_cnt;
                bit aborted;
                launched.push_back(tx_data);
                $display("TX launch data=0x%02h", tx_data);
                tx_busy  = 1'b1;
                wait_cnt = 0;
                aborted  = 1'b0;
                while (wait_cnt < 19 || engine_hold) begin
                    @(posedge PCLK); #1;
                    wait_cnt++;
                    if (PRESET) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    tx_done = 1'b1;
                    @(posedge PCLK); #1;
                    tx_done = 1'b0;
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] rdat;
        logic        err;
        logic [7:0]  d;
        int          n0;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; rx_data = '0; rx_done = 1'b0; rx_error = 1'b0; rx_busy = 1'b0;
        m_ovr = 0; m_frame = 0; m_txovf = 0; m_rx_en = 0;
        repeat (3) @(posedge PCLK);
        #1;
        check1("rst_tx_en", tx_en, 1'b0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check1("rst_pready", PREADY, 1'b0);
        check("rst_prdata", PRDATA, 32'd0);
        check1("rst_irq", irq, 1'b0);
        check1("rst_rx_en", rx_en, 1'b0);
        check("rst_baud", 32'(baud_div), 32'(DEFAULT_DIV));
        PRESET = 1'b0;
        apb_read(REG_STATUS_IDX(), rdat, err);
        check("rst_status", rdat, exp_status(1'b0));

        // 1: three characters through the TX path, with push-to-launch latency.
        apb_write(3'd0, 32'h3, err);
        m_rx_en = 1'b1;
        launched.delete();
        apb_write(3'd2, 32'h51, err);
        check1("t1_lat_early", tx_en, 1'b0);
        @(posedge PCLK); #1;
        check1("t1_lat_launch", tx_en, 1'b1);
        check("t1_lat_data", 32'(tx_data), 32'h51);
        apb_write(3'd2, 32'hA5, err);
        apb_write(3'd2, 32'h00, err);
        for (int i = 0; i < 600 && launched.size() < 3; i++) @(posedge PCLK);
        repeat (30) @(posedge PCLK);
        #1;
        check("t1_count", 32'(launched.size()), 32'd3);
        sent_exp = '{8'h51, 8'hA5, 8'h00};
        for (int i = 0; i < 3; i++)
            check($sformatf("t1_char%0d", i), (i < launched.size()) ? 32'(launched[i]) : 32'hDEAD, 32'(sent_exp[i]));
        apb_read(3'd1, rdat, err);
        check("t1_status", rdat, exp_status(1'b0));

        // 2: RX overrun after 17 characters, then drain.
        for (int i = 0; i <= 16; i++) rx_char(8'(i), 1'b0);
        apb_read(3'd1, rdat, err);
        check("t2_status_full", rdat, exp_status(1'b0));
        for (int i = 0; i < 16; i++) begin
            apb_read(3'd3, rdat, err);
            check($sformatf("t2_rd%0d", i), rdat, 32'(rxq.pop_front()));
            check1($sformatf("t2_rd%0d_err", i), err, 1'b0);
        end
        apb_read(3'd3, rdat, err);
        check("t2_empty_data", rdat, 32'd0);
        check1("t2_empty_err", err, 1'b1);

        // 3: frame error is sticky and clears independently of RX_OVR.
        rx_char(8'h77, 1'b1);
        apb_read(3'd1, rdat, err);
        check("t3_status_frame", rdat, exp_status(1'b0));
        apb_write(3'd1, 32'h080, err);
        m_frame = 1'b0;
        apb_read(3'd1, rdat, err);
        check("t3_status_w1c", rdat, exp_status(1'b0));
        apb_write(3'd1, 32'h040, err);
        m_ovr = 1'b0;

        // 4: TX overflow with TX disabled, then flush.
        apb_write(3'd0, 32'h2, err);
        n0 = launched.size();
        for (int i = 0; i < 17; i++) begin
            d = 8'($urandom);
            apb_write(3'd2, 32'(d), err);
            check1($sformatf("t4_push%0d_err", i), err, (txq.size() == TX_DEPTH));
            if (txq.size() == TX_DEPTH) m_txovf = 1'b1;
            else txq.push_back(d);
        end
        apb_read(3'd1, rdat, err);
        check("t4_status_full", rdat, exp_status(1'b0));
        apb_write(3'd0, 32'h4, err);
        m_rx_en = 1'b0;
        txq.delete();
        repeat (10) @(posedge PCLK);
        #1;
        check("t4_no_launch", 32'(launched.size()), 32'(n0));
        apb_read(3'd1, rdat, err);
        check("t4_status_flushed", rdat, exp_status(1'b0));
        apb_write(3'd1, 32'h100, err);
        m_txovf = 1'b0;

        // 5: RX-not-empty interrupt and baud divisor writes.
        apb_write(3'd4, 32'h1, err);
        apb_write(3'd0, 32'h3, err);
        m_rx_en = 1'b1;
        rx_char(8'h3C, 1'b0);
        check1("t5_irq_pre", irq, 1'b0);
        @(posedge PCLK); #1;
        check1("t5_irq_set", irq, 1'b1);
        apb_read(3'd3, rdat, err);
        check("t5_rx_data", rdat, 32'(rxq.pop_front()));
        check1("t5_irq_hold", irq, 1'b1);
        @(posedge PCLK); #1;
        check1("t5_irq_drop", irq, 1'b0);
        apb_write(3'd5, 32'd0, err);
        check1("t5_baud0_err", err, 1'b1);
        check("t5_baud0_val", 32'(baud_div), 32'(DEFAULT_DIV));
        apb_write(3'd5, 32'd868, err);
        check1("t5_baud_err", err, 1'b0);
        check("t5_baud_val", 32'(baud_div), 32'd868);
        apb_read(3'd6, rdat, err);
        check("t5_idx6_data", rdat, 32'd0);
        check1("t5_idx6_err", err, 1'b1);

        // Randomized RX traffic against the queue model.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 2) begin
                rx_char(8'($urandom), ($urandom_range(0, 9) == 0));
            end else begin
                apb_read(3'd3, rdat, err);
                if (rxq.size() == 0) begin
                    check("rnd_rd_empty", rdat, 32'd0);
                    check1("rnd_rd_empty_err", err, 1'b1);
                end else begin
                    check("rnd_rd", rdat, 32'(rxq.pop_front()));
                    check1("rnd_rd_err", err, 1'b0);
                end
            end
        end
        @(posedge PCLK); #1;
        check1("rnd_irq", irq, (rxq.size() != 0));
        apb_read(3'd1, rdat, err);
        check("rnd_status", rdat, exp_status(1'b0));
        apb_write(3'd1, 32'h1C0, err);
        m_ovr = 1'b0; m_frame = 1'b0; m_txovf = 1'b0;

        // Randomized TX bytes must launch in push order.
        launched.delete();
        sent_exp.delete();
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            sent_exp.push_back(d);
            apb_write(3'd2, 32'(d), err);
        end
        for (int i = 0; i < 2000 && launched.size() < 8; i++) @(posedge PCLK);
        repeat (30) @(posedge PCLK);
        #1;
        check("rnd_tx_count", 32'(launched.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("rnd_tx%0d", i), (i < launched.size()) ? 32'(launched[i]) : 32'hDEAD, 32'(sent_exp[i]));

        // 6: reset in the middle of a character with five bytes queued.
        engine_hold = 1'b1;
        launched.delete();
        for (int i = 0; i < 6; i++) apb_write(3'd2, 32'(8'($urandom)), err);
        repeat (3) @(posedge PCLK);
        #1;
        check("t6_launched", 32'(launched.size()), 32'd1);
        apb_read(3'd1, rdat, err);
        check("t6_tx_level", 32'(rdat[31:24]), 32'd5);
        check1("t6_tx_active", rdat[4], 1'b1);
        @(posedge PCLK); #3;
        PRESET = 1'b1;
        #1;
        check1("t6_tx_en", tx_en, 1'b0);
        check("t6_baud", 32'(baud_div), 32'(DEFAULT_DIV));
        check1("t6_irq", irq, 1'b0);
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        rxq.delete(); txq.delete();
        m_ovr = 0; m_frame = 0; m_txovf = 0; m_rx_en = 0;
        apb_read(3'd1, rdat, err);
        check("t6_status", rdat, exp_status(1'b0));
        apb_read(3'd0, rdat, err);
        check("t6_ctrl", rdat, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [2:0] REG_STATUS_IDX();
        return 3'd1;
    endfunction

endmodule
